control_sequencer: RTL and testbench

//  Hardwired control unit. Sits directly upstream of datapath and drives every datapath control strobe.

---
 rtl/control_sequencer_pkg.sv | 96 +++++++++
 rtl/reg_field_decoder.sv | 22 ++
 rtl/control_sequencer.sv | 232 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// ============================================================================
//  Module : control_sequencer_pkg
//  Brief  : Opcodes, ALU codes, state encoding and opcode classification
//           shared by the hardwired control sequencer.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

package control_sequencer_pkg;

    localparam int NREGS = 16;
    localparam int OPC_W = 5;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU3    = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_UNARY   = 3'd2,
        CLS_NOP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'd1;
    localparam logic [OPC_W-1:0] OP_AND  = 5'd2;
    localparam logic [OPC_W-1:0] OP_OR   = 5'd3;
    localparam logic [OPC_W-1:0] OP_SHR  = 5'd4;
    localparam logic [OPC_W-1:0] OP_SHL  = 5'd5;
    localparam logic [OPC_W-1:0] OP_ROR  = 5'd6;
    localparam logic [OPC_W-1:0] OP_ROL  = 5'd7;
    localparam logic [OPC_W-1:0] OP_MUL  = 5'd8;
    localparam logic [OPC_W-1:0] OP_DIV  = 5'd9;
    localparam logic [OPC_W-1:0] OP_NEG  = 5'd10;
    localparam logic [OPC_W-1:0] OP_NOT  = 5'd11;
    localparam logic [OPC_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OPC_W-1:0] OP_HALT = 5'd27;

    localparam logic [3:0] ALU_OR  = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_SHR = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_ROR = 4'd6;
    localparam logic [3:0] ALU_ROL = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_NEG = 4'd10;
    localparam logic [3:0] ALU_NOT = 4'd11;

    function automatic op_class_t op_class(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CLS_ALU3;
            OP_MUL, OP_DIV:                 return CLS_MULDIV;
            OP_NEG, OP_NOT:                 return CLS_UNARY;
            OP_NOP:                         return CLS_NOP;
            OP_HALT:                        return CLS_HALT;
            default:                        return CLS_ILLEGAL;
        endcase
    endfunction

    // Opcode and ALU numbering differ only for the four logic/arith ops.
    function automatic logic [3:0] alu_code(input logic [OPC_W-1:0] op);
        case (op)
            OP_ADD:  return ALU_ADD;
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_SHR:  return ALU_SHR;
            OP_SHL:  return ALU_SHL;
            OP_ROR:  return ALU_ROR;
            OP_ROL:  return ALU_ROL;
            OP_MUL:  return ALU_MUL;
            OP_DIV:  return ALU_DIV;
            OP_NEG:  return ALU_NEG;
            OP_NOT:  return ALU_NOT;
            default: return ALU_OR;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_field_decoder.sv
// ============================================================================
//  Module : reg_field_decoder
//  Brief  : 4-bit register index plus enable to one-hot register strobe.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_field_decoder
    import control_sequencer_pkg::*;
(
    input  logic [3:0]       idx,
    input  logic             en,
    output logic [NREGS-1:0] onehot
);

    for (genvar i = 0; i < NREGS; i++) begin : g_bit
        assign onehot[i] = en && (idx == 4'(i));
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ============================================================================
//  Module : control_sequencer
//  Brief  : Hardwired fetch/execute control unit driving all datapath strobes.
//           CTRL_ILLEGAL_HALT_EN: unknown opcodes halt and raise sticky illegal.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [3:0]  ALUop,
    output logic        run,
    output logic        illegal
);

    state_t           r_state;
    logic [OPC_W-1:0] w_op;
    logic [3:0]       w_ra;
    logic [3:0]       w_rb;
    logic [3:0]       w_rc;
    logic [14:0]      w_unused_ir;
    op_class_t        w_cls;
    logic [3:0]       w_alu;
    logic             w_rin_en;
    logic             w_rout_en;
    logic [3:0]       w_rin_sel;
    logic [3:0]       w_rout_sel;

    assign w_op        = ir[31:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ir[14:0];
    assign w_cls       = op_class(w_op);
    assign w_alu       = alu_code(w_op);

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (start) r_state <= S_T0;
                S_T0:   r_state <= S_T1;
                S_T1:   if (mem_ready) r_state <= S_T2;
                S_T2:   r_state <= S_T3;
                S_T3: begin
                    case (w_cls)
                        CLS_ALU3, CLS_MULDIV, CLS_UNARY: r_state <= S_T4;
                        CLS_HALT:                        r_state <= S_HALT;
`ifdef CTRL_ILLEGAL_HALT_EN
                        CLS_ILLEGAL:                     r_state <= S_HALT;
`endif
                        default:                         r_state <= S_T0;
                    endcase
                end
                S_T4: begin
                    if (w_cls == CLS_ALU3 || w_cls == CLS_MULDIV) r_state <= S_T5;
                    else                                          r_state <= S_T0;
                end
                S_T5: begin
                    if (w_cls == CLS_MULDIV) r_state <= S_T6;
                    else                     r_state <= S_T0;
                end
                S_T6:   r_state <= S_T0;
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CTRL_ILLEGAL_HALT_EN
    logic r_illegal;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_illegal <= 1'b0;
        end else if (r_state == S_T3 && w_cls == CLS_ILLEGAL) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal = r_illegal;
`else
    assign illegal = 1'b0;
`endif

    // Moore decode: state selects the step, IR fields select registers/ALU op.
    always_comb begin
        PCout      = 1'b0;
        MARin      = 1'b0;
        IncPC      = 1'b0;
        PCin       = 1'b0;
        Read       = 1'b0;
        MDRin      = 1'b0;
        MDRout     = 1'b0;
        IRin       = 1'b0;
        Yin        = 1'b0;
        Zlowin     = 1'b0;
        Zhighin    = 1'b0;
        Zlowout    = 1'b0;
        Zhighout   = 1'b0;
        HIin       = 1'b0;
        LOin       = 1'b0;
        ALUop      = ALU_OR;
        w_rin_en   = 1'b0;
        w_rin_sel  = 4'd0;
        w_rout_en  = 1'b0;
        w_rout_sel = 4'd0;
        run        = (r_state != S_IDLE) && (r_state != S_HALT);
        case (r_state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (w_cls)
                    CLS_ALU3: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        Yin        = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_ra;
                        Yin        = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        ALUop      = w_alu;
                        Zlowin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (w_cls)
                    CLS_ALU3: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rc;
                        ALUop      = w_alu;
                        Zlowin     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_rout_en  = 1'b1;
                        w_rout_sel = w_rb;
                        ALUop      = w_alu;
                        Zlowin     = 1'b1;
                        Zhighin    = 1'b1;
                    end
                    CLS_UNARY: begin
                        Zlowout   = 1'b1;
                        w_rin_en  = 1'b1;
                        w_rin_sel = w_ra;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_cls)
                    CLS_ALU3: begin
                        Zlowout   = 1'b1;
                        w_rin_en  = 1'b1;
                        w_rin_sel = w_ra;
                    end
                    CLS_MULDIV: begin
                        Zlowout = 1'b1;
                        LOin    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                if (w_cls == CLS_MULDIV) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    reg_field_decoder u_rin_dec (
        .idx    (w_rin_sel),
        .en     (w_rin_en),
        .onehot (Rin)
    );

    reg_field_decoder u_rout_dec (
        .idx    (w_rout_sel),
        .en     (w_rout_en),
        .onehot (Rout)
    );

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
//  Module : tb_control_sequencer
//  Brief  : Self-checking bench for control_sequencer using a per-cycle
//           stimulus/expectation queue.
//  Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    localparam logic [14:0] B_PCOUT    = 15'h4000;
    localparam logic [14:0] B_MARIN    = 15'h2000;
    localparam logic [14:0] B_INCPC    = 15'h1000;
    localparam logic [14:0] B_PCIN     = 15'h0800;
    localparam logic [14:0] B_READ     = 15'h0400;
    localparam logic [14:0] B_MDRIN    = 15'h0200;
    localparam logic [14:0] B_MDROUT   = 15'h0100;
    localparam logic [14:0] B_IRIN     = 15'h0080;
    localparam logic [14:0] B_YIN      = 15'h0040;
    localparam logic [14:0] B_ZLOWIN   = 15'h0020;
    localparam logic [14:0] B_ZHIGHIN  = 15'h0010;
    localparam logic [14:0] B_ZLOWOUT  = 15'h0008;
    localparam logic [14:0] B_ZHIGHOUT = 15'h0004;
    localparam logic [14:0] B_HIIN     = 15'h0002;
    localparam logic [14:0] B_LOIN     = 15'h0001;

    localparam logic [14:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZLOWIN;
    localparam logic [14:0] F_T1 = B_ZLOWOUT | B_PCIN | B_READ | B_MDRIN;
    localparam logic [14:0] F_T2 = B_MDROUT | B_IRIN;

    typedef struct packed {
        logic [14:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  aluop;
        logic        run;
        logic        ill;
    } outv_t;

    typedef struct packed {
        logic        clr;
        logic        st;
        logic        mr;
        logic [31:0] irv;
        outv_t       exp;
    } stim_t;

    logic        clock;
    logic        clear;
    logic        start;
    logic        mem_ready;
    logic [31:0] ir;
    logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [3:0]  ALUop;
    logic        run;
    logic        illegal;
    outv_t       act;

    stim_t sq[$];
    int    errors = 0;
    int    checks = 0;

    control_sequencer dut (
        .clock    (clock),
        .clear    (clear),
        .start    (start),
        .mem_ready(mem_ready),
        .ir       (ir),
        .PCout    (PCout),
        .MARin    (MARin),
        .IncPC    (IncPC),
        .PCin     (PCin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zlowin   (Zlowin),
        .Zhighin  (Zhighin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .HIin     (HIin),
        .LOin     (LOin),
        .Rin      (Rin),
        .Rout     (Rout),
        .ALUop    (ALUop),
        .run      (run),
        .illegal  (illegal)
    );

    assign act = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
                  Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin,
                  Rin, Rout, ALUop, run, illegal};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk_ir(input int op, input int ra, input int rb, input int rc);
        return {op[4:0], ra[3:0], rb[3:0], rc[3:0], 15'd0};
    endfunction

    // One entry: inputs driven before an edge, outputs expected after it.
    task automatic push(input logic clr, input logic st, input logic mr, input logic [31:0] irv,
                        input logic [14:0] strb, input logic [15:0] rin_v, input logic [15:0] rout_v,
                        input logic [3:0] alu, input logic run_v, input logic ill_v);
        stim_t s;
        s.clr       = clr;
        s.st        = st;
        s.mr        = mr;
        s.irv       = irv;
        s.exp.strb  = strb;
        s.exp.rin   = rin_v;
        s.exp.rout  = rout_v;
        s.exp.aluop = alu;
        s.exp.run   = run_v;
        s.exp.ill   = ill_v;
        sq.push_back(s);
    endtask

    // Fetch steps T0..T2; ir0 is held on the edge into T0, irv afterwards.
    task automatic push_fetch(input logic st, input logic [31:0] ir0, input logic [31:0] irv, input int stall);
        push(1'b0, st, 1'b1, ir0, F_T0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b0, irv, F_T1, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < stall; i++)
            push(1'b0, 1'b0, 1'b0, irv, F_T1, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, irv, F_T2, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset;
        stim_t s;
        int    n = 0;
        push(1'b1, 1'b0, 1'b0, 32'h0, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, 32'h0, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            push(1'b0, 1'b0, 1'b0, 32'h0, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            clear = s.clr; start = s.st; mem_ready = s.mr; ir = s.irv;
            @(posedge clock); #1;
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL reset step%0d: got %h expected %h", n, act, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_alu3;
        stim_t       s;
        int          n = 0;
        logic [31:0] i_or = mk_ir(3, 2, 5, 6);
        push_fetch(1'b1, i_or, i_or, 0);
        push(1'b0, 1'b0, 1'b1, i_or, B_YIN,     16'h0,    16'h0020, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_or, B_ZLOWIN,  16'h0,    16'h0040, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_or, B_ZLOWOUT, 16'h0004, 16'h0,    4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_or, F_T0,      16'h0,    16'h0,    4'd0, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, i_or, 15'h0,     16'h0,    16'h0,    4'd0, 1'b0, 1'b0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            clear = s.clr; start = s.st; mem_ready = s.mr; ir = s.irv;
            @(posedge clock); #1;
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL alu3_or step%0d: got %h expected %h", n, act, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_mem_stall;
        stim_t       s;
        int          n = 0;
        logic [31:0] i_sub = mk_ir(1, 7, 1, 15);
        push_fetch(1'b1, i_sub, i_sub, 3);
        push(1'b0, 1'b0, 1'b1, i_sub, B_YIN,     16'h0,    16'h0002, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_sub, B_ZLOWIN,  16'h0,    16'h8000, 4'd3, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_sub, B_ZLOWOUT, 16'h0080, 16'h0,    4'd0, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, i_sub, 15'h0,     16'h0,    16'h0,    4'd0, 1'b0, 1'b0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            clear = s.clr; start = s.st; mem_ready = s.mr; ir = s.irv;
            @(posedge clock); #1;
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL mem_stall step%0d: got %h expected %h", n, act, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_muldiv;
        stim_t       s;
        int          n = 0;
        logic [31:0] i_mul = mk_ir(8, 3, 3, 0);
        push_fetch(1'b1, i_mul, i_mul, 0);
        push(1'b0, 1'b0, 1'b1, i_mul, B_YIN,                  16'h0, 16'h0008, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_mul, B_ZLOWIN | B_ZHIGHIN,   16'h0, 16'h0008, 4'd8, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_mul, B_ZLOWOUT | B_LOIN,     16'h0, 16'h0,    4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_mul, B_ZHIGHOUT | B_HIIN,    16'h0, 16'h0,    4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_mul, F_T0,                   16'h0, 16'h0,    4'd0, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, i_mul, 15'h0,                  16'h0, 16'h0,    4'd0, 1'b0, 1'b0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            clear = s.clr; start = s.st; mem_ready = s.mr; ir = s.irv;
            @(posedge clock); #1;
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL muldiv step%0d: got %h expected %h", n, act, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_halt;
        stim_t       s;
        int          n = 0;
        logic [31:0] i_halt = mk_ir(27, 0, 0, 0);
        push_fetch(1'b1, i_halt, i_halt, 0);
        push(1'b0, 1'b0, 1'b1, i_halt, 15'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b1, 1'b1, i_halt, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1, i_halt, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        push(1'b0, 1'b1, 1'b1, i_halt, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        push(1'b1, 1'b0, 1'b0, i_halt, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, i_halt, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            clear = s.clr; start = s.st; mem_ready = s.mr; ir = s.irv;
            @(posedge clock); #1;
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL halt step%0d: got %h expected %h", n, act, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_illegal_and_clear;
        stim_t       s;
        int          n = 0;
        logic [31:0] i_bad = mk_ir(31, 0, 0, 0);
        logic [31:0] i_add = mk_ir(0, 1, 2, 3);
        push_fetch(1'b1, i_bad, i_bad, 0);
        push(1'b0, 1'b0, 1'b1, i_bad, 15'h0, 16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
`ifdef CTRL_ILLEGAL_HALT_EN
        push(1'b0, 1'b0, 1'b1, i_bad, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b1, i_bad, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b1);
`else
        push(1'b0, 1'b0, 1'b1, i_bad, F_T0,  16'h0, 16'h0, 4'd0, 1'b1, 1'b0);
`endif
        push(1'b1, 1'b0, 1'b0, i_bad, 15'h0, 16'h0, 16'h0, 4'd0, 1'b0, 1'b0);
        // Clear while in T4 must kill the T5 register write.
        push_fetch(1'b1, i_add, i_add, 0);
        push(1'b0, 1'b0, 1'b1, i_add, B_YIN,    16'h0, 16'h0004, 4'd0, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_add, B_ZLOWIN, 16'h0, 16'h0008, 4'd2, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, i_add, 15'h0,    16'h0, 16'h0,    4'd0, 1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_add, 15'h0,    16'h0, 16'h0,    4'd0, 1'b0, 1'b0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            clear = s.clr; start = s.st; mem_ready = s.mr; ir = s.irv;
            @(posedge clock); #1;
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL illegal_clear step%0d: got %h expected %h", n, act, s.exp);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back;
        stim_t       s;
        int          n = 0;
        logic [31:0] i_neg = mk_ir(10, 4, 9, 0);
        logic [31:0] i_nop = mk_ir(26, 0, 0, 0);
        logic [31:0] i_add = mk_ir(0, 0, 0, 0);
        push_fetch(1'b1, i_neg, i_neg, 0);
        push(1'b0, 1'b0, 1'b1, i_neg, B_ZLOWIN,  16'h0,    16'h0200, 4'd10, 1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_neg, B_ZLOWOUT, 16'h0010, 16'h0,    4'd0,  1'b1, 1'b0);
        push_fetch(1'b0, i_neg, i_nop, 1);
        push(1'b0, 1'b0, 1'b1, i_nop, 15'h0,     16'h0,    16'h0,    4'd0,  1'b1, 1'b0);
        push_fetch(1'b0, i_nop, i_add, 0);
        push(1'b0, 1'b0, 1'b1, i_add, B_YIN,     16'h0,    16'h0001, 4'd0,  1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_add, B_ZLOWIN,  16'h0,    16'h0001, 4'd2,  1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_add, B_ZLOWOUT, 16'h0001, 16'h0,    4'd0,  1'b1, 1'b0);
        push(1'b0, 1'b0, 1'b1, i_add, F_T0,      16'h0,    16'h0,    4'd0,  1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, i_add, 15'h0,     16'h0,    16'h0,    4'd0,  1'b0, 1'b0);
        while (sq.size() > 0) begin
            s = sq.pop_front();
            clear = s.clr; start = s.st; mem_ready = s.mr; ir = s.irv;
            @(posedge clock); #1;
            checks++;
            if (act !== s.exp) begin
                errors++;
                $display("FAIL back_to_back step%0d: got %h expected %h", n, act, s.exp);
            end
            n++;
        end
    endtask

    initial begin
        clear     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        ir        = 32'h0;
        test_reset();
        test_alu3();
        test_mem_stall();
        test_muldiv();
        test_halt();
        test_illegal_and_clear();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
